cache_mem_arbiter: RTL and testbench
====================================

// Module: cache_mem_arbiter
// PURPOSE
// - Shares the single physical-memory port between the I-cache and D-cache miss paths of the pipelined RV32I core.
// - Sits between the two caches' line-fill/writeback interfaces and pmem.
// - Grants one requester at a time and holds that grant for the full pmem transaction.
// - Routes the response back to the granted cache only.
// PARAMETERS
// ADDR_W   32   pmem/cache address width (line-aligned addresses)
// LINE_W   256  cache line width in bits
// PORTS
// clk           in   1       core clock
// rst           in   1       synchronous, active-high reset
// i_read        in   1       I-cache line-fill request (level, held until i_resp)
// i_address     in   ADDR_W  I-cache request address
// i_rdata       out  LINE_W  line returned to I-cache
// i_resp        out  1       I-cache transaction done (1-cycle pulse)
// d_read        in   1       D-cache line-fill request (level, held until d_resp)
// d_write       in   1       D-cache writeback request (level, held until d_resp)
// d_address     in   ADDR_W  D-cache request address
// d_wdata       in   LINE_W  D-cache writeback line
// d_rdata       out  LINE_W  line returned to D-cache
// d_resp        out  1       D-cache transaction done (1-cycle pulse)
// pmem_read     out  1       memory read command
// pmem_write    out  1       memory write command
// pmem_address  out  ADDR_W  memory address
// pmem_wdata    out  LINE_W  memory write line
// pmem_rdata    in   LINE_W  memory read line
// pmem_resp     in   1       memory transaction done
// BEHAVIOUR
// - States:
//   - IDLE: no grant.
//   - SERVE_I: I-cache granted.
//   - SERVE_D: D-cache granted.
//   - RECOVER: one dead cycle after every completion so the served cache can drop its request.
// - Reset (sync, active-high, any state including mid-transaction):
//   - Next state IDLE.
//   - All outputs 0 in the cycle after rst is sampled high.
//   - A transaction in flight is abandoned; a late pmem_resp arriving in IDLE is ignored.
// - IDLE, request sampled at edge t:
//   - Grant register updated; state SERVE_x at t+1.
//   - Requester's address (and d_wdata, read/write kind) latched at edge t into hold registers.
// - SERVE_x: pmem_read/pmem_write/pmem_address/pmem_wdata driven from hold registers, stable until pmem_resp.
//   - Requester inputs that change mid-transaction are ignored.
// - Completion: cycle where pmem_resp=1 in SERVE_x.
//   - x_resp=1 that same cycle (combinational from pmem_resp); x_rdata=pmem_rdata that cycle.
//   - Next state RECOVER, then IDLE.
//   - Minimum spacing between grants: 2 cycles after resp.
// - Non-granted cache: resp held 0; rdata output held 0.
// - pmem_resp in IDLE or RECOVER: ignored, no resp pulse.
// - d_read and d_write both high: treated as write. Sim-only assertion fires.
// - Latency:
//   - Request to pmem command: 1 cycle.
//   - pmem_resp to x_resp: 0 cycles.
// - Arbitration when both request in the same IDLE cycle: see CONFIGURATION.
//   - A lone requester is always granted immediately.
// CONFIGURATION
// - ARB_ROUND_ROBIN_EN defined:
//   - 1-bit last_grant register; reset value = I.
//   - On simultaneous requests the cache NOT served last is granted.
//   - last_grant updates on every completion.
// - ARB_ROUND_ROBIN_EN undefined:
//   - Fixed priority, D-cache wins every tie. No last_grant register.
//   - Reason: load/store stalls are more costly than fetch stalls.
// TESTING
// 1. Lone I-fill:
//    - Stimulus: i_read=1, addr 0x0000_0060 at t; mem resp 5 cycles later.
//    - Required: pmem_read=1/addr 0x60 from t+1; i_resp pulse with line data; d_resp=0 throughout.
// 2. Lone D-writeback:
//    - Stimulus: d_write=1, addr 0x8000_0020, wdata pattern A5..A5.
//    - Required: pmem_write=1, pmem_wdata=pattern until resp; d_resp 1 cycle; then RECOVER, IDLE.
// 3. Tie, default build:
//    - Stimulus: i_read and d_read both asserted at t.
//    - Required: D served first; I granted 2 cycles after d_resp.
// 4. Tie, ARB_ROUND_ROBIN_EN:
//    - Stimulus: three back-to-back ties.
//    - Required: grant order D, I, D (reset last_grant=I).
// 5. Reset mid-SERVE_D:
//    - Stimulus: rst pulsed 2 cycles into a D read; later pmem_resp=1 in IDLE.
//    - Required: pmem_read=0 next cycle, no d_resp.
// 6. Address hold:
//    - Stimulus: i_address changed mid-SERVE_I.
//    - Required: pmem_address stays at the latched value.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// Arbiter sharing one pmem port between the I-cache and D-cache miss paths.
// Optional build macro ARB_ROUND_ROBIN_EN: round-robin tie-breaking instead of D-cache priority.
module cache_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RECOVER} state_t;

    state_t            state_q;
    logic              rd_q;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic              req_i;
    logic              req_d;
    logic              grant_d;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant_q;  // 0 = I-cache served last, 1 = D-cache
`endif

    always_comb begin
        req_i = i_read;
        req_d = d_read | d_write;
`ifdef ARB_ROUND_ROBIN_EN
        grant_d = req_d && (!req_i || !last_grant_q);
`else
        // Load/store stalls hurt more than fetch stalls, so D wins ties.
        grant_d = req_d;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        state_q <= SERVE_D;
                        rd_q    <= !d_write;
                        wr_q    <= d_write;
                        addr_q  <= d_address;
                        wdata_q <= d_write ? d_wdata : '0;
                    end else if (req_i) begin
                        state_q <= SERVE_I;
                        rd_q    <= 1'b1;
                        wr_q    <= 1'b0;
                        addr_q  <= i_address;
                        wdata_q <= '0;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (pmem_resp) begin
                        state_q <= RECOVER;
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b0;
                        addr_q  <= '0;
                        wdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant_q <= (state_q == SERVE_D);
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Responses are combinational so the granted cache sees pmem_resp with zero latency.
    always_comb begin
        i_resp  = (state_q == SERVE_I) && pmem_resp;
        d_resp  = (state_q == SERVE_D) && pmem_resp;
        i_rdata = i_resp ? pmem_rdata : '0;
        d_rdata = d_resp ? pmem_rdata : '0;
    end

    assign pmem_read    = rd_q;
    assign pmem_write   = wr_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

`ifndef SYNTHESIS
    // A D-cache asking for fill and writeback together is a cache bug; the write wins.
    assert property (@(posedge clk) disable iff (rst) !(d_read && d_write));
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: table-driven lone transactions
// plus hand-written tie, reset and recovery sequences.
module tb_cache_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic              isD;
        logic              isWr;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
        logic [LINE_W-1:0] rdata;
        int                lat;
    } txn_t;

    txn_t vecs[4];
    logic expD[4];

    cache_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    task automatic checkBit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic checkAddr(input string name, input logic [ADDR_W-1:0] act, input logic [ADDR_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkQuiet(input string tag);
        checkBit({tag, "_pmem_read"}, pmem_read, 1'b0);
        checkBit({tag, "_pmem_write"}, pmem_write, 1'b0);
        checkBit({tag, "_i_resp"}, i_resp, 1'b0);
        checkBit({tag, "_d_resp"}, d_resp, 1'b0);
        checkOutput({tag, "_i_rdata"}, i_rdata, '0);
        checkOutput({tag, "_d_rdata"}, d_rdata, '0);
    endtask

    // One lone transaction: request, command hold (with corrupted requester inputs),
    // completion pulse, then a RECOVER cycle that must ignore a stray pmem_resp.
    task automatic applyStimulus(input txn_t v);
        nextCycle();
        if (v.isD) begin
            d_read = !v.isWr; d_write = v.isWr; d_address = v.addr; d_wdata = v.wdata;
        end else begin
            i_read = 1'b1; i_address = v.addr;
        end
        nextCycle();
        for (int c = 1; c < v.lat; c++) begin
            @(negedge clk);
            checkBit("cmd_read", pmem_read, !v.isWr);
            checkBit("cmd_write", pmem_write, v.isWr);
            checkAddr("cmd_addr", pmem_address, v.addr);
            checkOutput("cmd_wdata", pmem_wdata, v.wdata);
            checkBit("wait_i_resp", i_resp, 1'b0);
            checkBit("wait_d_resp", d_resp, 1'b0);
            if (c == 1) begin
                if (v.isD) begin
                    d_address = ~v.addr; d_wdata = ~v.wdata;
                end else begin
                    i_address = ~v.addr;
                end
            end
            nextCycle();
        end
        pmem_resp = 1'b1;
        pmem_rdata = v.rdata;
        @(negedge clk);
        checkAddr("done_addr_held", pmem_address, v.addr);
        checkOutput("done_wdata_held", pmem_wdata, v.wdata);
        checkBit("done_i_resp", i_resp, !v.isD);
        checkBit("done_d_resp", d_resp, v.isD);
        checkOutput("done_i_rdata", i_rdata, v.isD ? '0 : v.rdata);
        checkOutput("done_d_rdata", d_rdata, v.isD ? v.rdata : '0);
        nextCycle();
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        pmem_rdata = {8{32'h5A5A_1234}};
        @(negedge clk);
        checkQuiet("recover");
        nextCycle();
        pmem_resp = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0060, '0, {8{32'h1111_0060}}, 5};
        vecs[1] = '{1'b1, 1'b1, 32'h8000_0020, {32{8'hA5}}, {8{32'h0BAD_0001}}, 3};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_1240, '0, {8{32'h2222_1240}}, 2};
        vecs[3] = '{1'b0, 1'b0, 32'hFFFF_FFE0, '0, {8{32'h3333_FFE0}}, 4};
`ifdef ARB_ROUND_ROBIN_EN
        expD = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        expD = '{1'b1, 1'b1, 1'b1, 1'b0};
`endif

        rst = 1'b1;
        i_read = 1'b0; i_address = '0;
        d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
        pmem_rdata = {8{32'hDEAD_BEEF}}; pmem_resp = 1'b1;
        nextCycle();
        nextCycle();
        @(negedge clk);
        checkQuiet("reset");
        checkAddr("reset_addr", pmem_address, '0);
        checkOutput("reset_wdata", pmem_wdata, '0);
        nextCycle();
        rst = 1'b0; pmem_resp = 1'b0;
        @(negedge clk);
        checkQuiet("idle_after_reset");

        for (int k = 0; k < 4; k++) applyStimulus(vecs[k]);

        // Ties: the served cache drops in RECOVER and re-raises in IDLE, except after round 2.
        nextCycle();
        i_read = 1'b1; i_address = 32'h0000_0100;
        d_read = 1'b1; d_address = 32'h0000_0200;
        for (int k = 0; k < 4; k++) begin
            nextCycle();
            @(negedge clk);
            checkBit("tie_pmem_read", pmem_read, 1'b1);
            checkAddr("tie_grant_addr", pmem_address, expD[k] ? 32'h0000_0200 : 32'h0000_0100);
            nextCycle();
            pmem_resp = 1'b1;
            pmem_rdata = {8{32'hC0DE_0000 + k}};
            @(negedge clk);
            checkBit("tie_d_resp", d_resp, expD[k]);
            checkBit("tie_i_resp", i_resp, !expD[k]);
            checkOutput("tie_d_rdata", d_rdata, expD[k] ? {8{32'hC0DE_0000 + k}} : '0);
            checkOutput("tie_i_rdata", i_rdata, expD[k] ? '0 : {8{32'hC0DE_0000 + k}});
            nextCycle();
            pmem_resp = 1'b0;
            if (expD[k]) d_read = 1'b0; else i_read = 1'b0;
            @(negedge clk);
            checkBit("tie_recover_read", pmem_read, 1'b0);
            nextCycle();
            if (k < 2) begin
                if (expD[k]) d_read = 1'b1; else i_read = 1'b1;
            end
            @(negedge clk);
            checkBit("tie_idle_read", pmem_read, 1'b0);
        end

        // Reset two cycles into a D read, then a late pmem_resp in IDLE.
        nextCycle();
        d_read = 1'b1; d_address = 32'h0000_0300;
        nextCycle();
        nextCycle();
        @(negedge clk);
        checkBit("pre_reset_read", pmem_read, 1'b1);
        rst = 1'b1;
        nextCycle();
        rst = 1'b0; d_read = 1'b0;
        @(negedge clk);
        checkBit("abort_pmem_read", pmem_read, 1'b0);
        checkAddr("abort_addr", pmem_address, '0);
        nextCycle();
        pmem_resp = 1'b1; pmem_rdata = {8{32'hFEED_F00D}};
        @(negedge clk);
        checkQuiet("late_resp_idle");
        nextCycle();
        pmem_resp = 1'b0;
        nextCycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
